mean_update: RTL and testbench

MEAN_UPDATE -- requirements
Module: mean_update

---
 rtl/mean_update.sv | 186 ++++++++++++++++++
 tb/tb_mean_update.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mean_update.sv
// Recomputes the 16 cluster means (8-bit R,G,B) from accumulated sums and pixel counts
// using one shared restoring divider. Define MEAN_UPDATE_ROUND_EN for round-half-up means.
module mean_update #(
    parameter int ACC_W = 32,
    parameter int CNT_W = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [48*ACC_W-1:0]  accumolator,
    input  logic [16*CNT_W-1:0]  counters,
    output logic [383:0]         meanOut,
    output logic [15:0]          enabled,
    output logic                 busy,
    output logic                 done,
    output logic                 converged,
    output logic [2:0]           state_o
);

`ifdef MEAN_UPDATE_ROUND_EN
    localparam int DW = ACC_W + 1;
`else
    localparam int DW = ACC_W;
`endif
    localparam int BW = $clog2(DW);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        DIV   = 3'd2,
        STORE = 3'd3,
        NEXT  = 3'd4,
        DONE  = 3'd5
    } state_e;

    state_e           state_q;
    logic [ACC_W-1:0] acc_q [48];
    logic [CNT_W-1:0] cnt_q [16];
    logic [7:0]       mean_q [48];
    logic [3:0]       clu_q;
    logic [1:0]       ch_q;
    logic [DW-1:0]    dvd_q;
    logic [CNT_W:0]   rem_q;
    logic [BW-1:0]    bit_q;
    logic [15:0]      en_q;
    logic             busy_q;
    logic             done_q;
    logic             conv_q;
    logic             chg_q;

    logic [5:0]       word_idx;
    logic [ACC_W-1:0] cur_sum;
    logic [CNT_W-1:0] cur_cnt;
    logic [CNT_W-1:0] nxt_cnt;
    logic [DW-1:0]    dividend;
    logic [CNT_W:0]   rem_sh;
    logic             rem_ge;
    logic [7:0]       q_sat;
    logic [7:0]       old_byte;

    // Word/byte index of the current cluster+channel; R sits at the highest slot of a cluster.
    always_comb begin
        word_idx = 6'({2'b00, clu_q} * 6'd3) + 6'd2 - {4'b0000, ch_q};
        cur_sum  = acc_q[word_idx];
        cur_cnt  = cnt_q[clu_q];
        nxt_cnt  = cnt_q[clu_q + 4'd1];
        old_byte = mean_q[word_idx];
`ifdef MEAN_UPDATE_ROUND_EN
        dividend = {1'b0, cur_sum} + DW'(cur_cnt >> 1);
`else
        dividend = cur_sum;
`endif
        rem_sh   = (rem_q << 1) | {{CNT_W{1'b0}}, dvd_q[DW-1]};
        rem_ge   = (rem_sh >= {1'b0, cur_cnt});
        q_sat    = (|dvd_q[DW-1:8]) ? 8'hFF : dvd_q[7:0];
    end

    always_comb begin
        meanOut = '0;
        for (int k = 0; k < 48; k++) begin
            meanOut[k*8 +: 8] = mean_q[k];
        end
    end

    assign enabled   = en_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign converged = conv_q;
    assign state_o   = state_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            for (int k = 0; k < 48; k++) begin
                acc_q[k]  <= '0;
                mean_q[k] <= 8'((k / 3) * 17);
            end
            for (int k = 0; k < 16; k++) begin
                cnt_q[k] <= '0;
            end
            clu_q   <= '0;
            ch_q    <= '0;
            dvd_q   <= '0;
            rem_q   <= '0;
            bit_q   <= '0;
            en_q    <= 16'hFFFF;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            conv_q  <= 1'b0;
            chg_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        for (int k = 0; k < 48; k++) begin
                            acc_q[k] <= accumolator[k*ACC_W +: ACC_W];
                        end
                        for (int k = 0; k < 16; k++) begin
                            cnt_q[k] <= counters[k*CNT_W +: CNT_W];
                        end
                        chg_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        clu_q   <= '0;
                        ch_q    <= '0;
                        state_q <= (counters[CNT_W-1:0] != '0) ? LOAD : NEXT;
                    end
                end
                LOAD: begin
                    dvd_q   <= dividend;
                    rem_q   <= '0;
                    bit_q   <= BW'(DW - 1);
                    state_q <= DIV;
                end
                DIV: begin
                    // Quotient bits shift in from the bottom as dividend bits leave the top.
                    rem_q <= rem_ge ? (rem_sh - {1'b0, cur_cnt}) : rem_sh;
                    dvd_q <= {dvd_q[DW-2:0], rem_ge};
                    bit_q <= bit_q - 1'b1;
                    if (bit_q == '0) begin
                        state_q <= STORE;
                    end
                end
                STORE: begin
                    mean_q[word_idx] <= q_sat;
                    if (q_sat != old_byte) begin
                        chg_q <= 1'b1;
                    end
                    if (ch_q == 2'd2) begin
                        en_q[clu_q] <= 1'b1;
                        if (clu_q == 4'd15) begin
                            state_q <= DONE;
                        end else begin
                            clu_q   <= clu_q + 4'd1;
                            ch_q    <= '0;
                            state_q <= (nxt_cnt != '0) ? LOAD : NEXT;
                        end
                    end else begin
                        ch_q    <= ch_q + 2'd1;
                        state_q <= LOAD;
                    end
                end
                NEXT: begin
                    en_q[clu_q] <= 1'b0;
                    if (clu_q == 4'd15) begin
                        state_q <= DONE;
                    end else begin
                        clu_q   <= clu_q + 4'd1;
                        ch_q    <= '0;
                        state_q <= (nxt_cnt != '0) ? LOAD : NEXT;
                    end
                end
                DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    conv_q  <= ~chg_q;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mean_update.sv
// Directed bench for mean_update: reset values, latency, zero clusters, saturation,
// rounding, convergence, ignored start and mid-pass reset.
module tb_mean_update;
  localparam int ACC_W = 32;
  localparam int CNT_W = 20;
`ifdef MEAN_UPDATE_ROUND_EN
  localparam bit RND = 1'b1;
  localparam int LAT_ALL = 1681;
  localparam int LAT_Z = 1577;
  localparam logic [23:0] ROUND_EXP = 24'h020103;
`else
  localparam bit RND = 1'b0;
  localparam int LAT_ALL = 1633;
  localparam int LAT_Z = 1532;
  localparam logic [23:0] ROUND_EXP = 24'h010102;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic [48*ACC_W-1:0] accumolator = '0;
  logic [16*CNT_W-1:0] counters = '0;
  logic [383:0] meanOut;
  logic [15:0] enabled;
  logic busy, done, converged;
  logic [2:0] state_o;

  int n_cmp = 0;
  int n_fail = 0;

  int unsigned sum_a [16][3];
  int unsigned cnt_a [16];
  logic [7:0] pm [16][3];

  mean_update #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .accumolator(accumolator),
    .counters(counters), .meanOut(meanOut), .enabled(enabled), .busy(busy),
    .done(done), .converged(converged), .state_o(state_o)
  );

  always #5 clk = ~clk;

  function automatic logic [383:0] pack_mean();
    logic [383:0] v;
    v = '0;
    for (int i = 0; i < 16; i++)
      for (int c = 0; c < 3; c++) v[24*i + 8*(2-c) +: 8] = pm[i][c];
    return v;
  endfunction

  function automatic logic [15:0] exp_enabled();
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) v[i] = (cnt_a[i] != 0);
    return v;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 16; i++)
      for (int c = 0; c < 3; c++) pm[i][c] = 8'(i * 17);
  endfunction

  // Returns 1 when some mean byte changes.
  function automatic bit model_pass();
    bit chg;
    longint unsigned q;
    logic [7:0] b;
    chg = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (cnt_a[i] != 0) begin
        for (int c = 0; c < 3; c++) begin
          q = longint'(sum_a[i][c]);
          if (RND) q = q + cnt_a[i] / 2;
          q = q / cnt_a[i];
          b = (q > 255) ? 8'hFF : q[7:0];
          if (b != pm[i][c]) chg = 1'b1;
          pm[i][c] = b;
        end
      end
    end
    return chg;
  endfunction

  task automatic fill_default(input int unsigned c);
    for (int i = 0; i < 16; i++) begin
      cnt_a[i] = c;
      sum_a[i][0] = c * (i * 16);
      sum_a[i][1] = c * (i * 8 + 1);
      sum_a[i][2] = c * (255 - i);
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < 16; i++) begin
      counters[i*CNT_W +: CNT_W] = CNT_W'(cnt_a[i]);
      for (int c = 0; c < 3; c++) accumolator[(3*i + 2 - c)*ACC_W +: ACC_W] = sum_a[i][c];
    end
  endtask

  task automatic do_reset();
    start = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  // Pulses start, optionally re-pulses it `mid` cycles in, and measures start-edge-to-done latency.
  task automatic run_pass(input int mid, output int lat, output logic busy_seen, output int done_cyc);
    int n;
    drive_inputs();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    busy_seen = busy;
    while (done !== 1'b1 && n < 4000) begin
      @(negedge clk);
      n++;
      start = (n == mid);
    end
    start = 1'b0;
    lat = (done === 1'b1) ? n : -1;
    done_cyc = 0;
    while (done === 1'b1 && done_cyc < 10) begin
      done_cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [383:0] e;
    do_reset();
    e = pack_mean();
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_cmp++; if (converged !== 1'b0) begin n_fail++; $display("FAIL reset_conv: got %b expected 0", converged); end
    n_cmp++; if (enabled !== 16'hFFFF) begin n_fail++; $display("FAIL reset_en: got %h expected ffff", enabled); end
    n_cmp++; if (meanOut[5*24 +: 24] !== 24'h555555) begin n_fail++; $display("FAIL reset_mean5: got %h expected 555555", meanOut[5*24 +: 24]); end
    n_cmp++; if (meanOut !== e) begin n_fail++; $display("FAIL reset_mean: got %h expected %h", meanOut, e); end
  endtask

  task automatic test_basic();
    int lat, dc; logic bs; bit chg;
    fill_default(100);
    sum_a[0][0] = 1600; sum_a[0][1] = 3200; sum_a[0][2] = 0;
    run_pass(0, lat, bs, dc);
    chg = model_pass();
    n_cmp++; if (lat != LAT_ALL) begin n_fail++; $display("FAIL basic_latency: got %0d expected %0d", lat, LAT_ALL); end
    n_cmp++; if (bs !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b expected 1", bs); end
    n_cmp++; if (dc != 1) begin n_fail++; $display("FAIL basic_done_width: got %0d expected 1", dc); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after: got %b expected 0", busy); end
    n_cmp++; if (meanOut[23:0] !== 24'h102000) begin n_fail++; $display("FAIL basic_mean0: got %h expected 102000", meanOut[23:0]); end
    n_cmp++; if (meanOut !== pack_mean()) begin n_fail++; $display("FAIL basic_mean: got %h expected %h", meanOut, pack_mean()); end
    n_cmp++; if (enabled !== 16'hFFFF) begin n_fail++; $display("FAIL basic_en: got %h expected ffff", enabled); end
    n_cmp++; if (converged !== !chg) begin n_fail++; $display("FAIL basic_conv: got %b expected %b", converged, !chg); end
  endtask

  task automatic test_zero_cluster();
    int lat, dc; logic bs; bit chg;
    do_reset();
    fill_default(50);
    cnt_a[5] = 0;
    run_pass(0, lat, bs, dc);
    chg = model_pass();
    n_cmp++; if (lat != LAT_Z) begin n_fail++; $display("FAIL zero_latency: got %0d expected %0d", lat, LAT_Z); end
    n_cmp++; if (meanOut[5*24 +: 24] !== 24'h555555) begin n_fail++; $display("FAIL zero_mean5: got %h expected 555555", meanOut[5*24 +: 24]); end
    n_cmp++; if (enabled !== 16'hFFDF) begin n_fail++; $display("FAIL zero_en: got %h expected ffdf", enabled); end
    n_cmp++; if (meanOut !== pack_mean()) begin n_fail++; $display("FAIL zero_mean: got %h expected %h", meanOut, pack_mean()); end
    n_cmp++; if (converged !== !chg) begin n_fail++; $display("FAIL zero_conv: got %b expected %b", converged, !chg); end
  endtask

  task automatic test_saturate();
    int lat, dc; logic bs; bit chg;
    fill_default(10);
    sum_a[3][0] = 3000; sum_a[3][1] = 3000; sum_a[3][2] = 3000;
    cnt_a[11] = 1; sum_a[11][0] = 32'hFFFF_FFFF; sum_a[11][1] = 255; sum_a[11][2] = 256;
    run_pass(0, lat, bs, dc);
    chg = model_pass();
    n_cmp++; if (meanOut[3*24 +: 24] !== 24'hFFFFFF) begin n_fail++; $display("FAIL sat_mean3: got %h expected ffffff", meanOut[3*24 +: 24]); end
    n_cmp++; if (meanOut[11*24 +: 24] !== 24'hFFFFFF) begin n_fail++; $display("FAIL sat_mean11: got %h expected ffffff", meanOut[11*24 +: 24]); end
    n_cmp++; if (enabled !== 16'hFFFF) begin n_fail++; $display("FAIL sat_en: got %h expected ffff", enabled); end
    n_cmp++; if (meanOut !== pack_mean()) begin n_fail++; $display("FAIL sat_mean: got %h expected %h", meanOut, pack_mean()); end
  endtask

  task automatic test_round();
    int lat, dc; logic bs; bit chg;
    fill_default(10);
    sum_a[7][0] = 15; sum_a[7][1] = 14; sum_a[7][2] = 25;
    cnt_a[9] = 20'hFFFFF;
    sum_a[9][0] = 255 * 32'hFFFFF; sum_a[9][1] = 128 * 32'hFFFFF; sum_a[9][2] = 32'hFFFFF;
    run_pass(0, lat, bs, dc);
    chg = model_pass();
    n_cmp++; if (meanOut[7*24 +: 24] !== ROUND_EXP) begin n_fail++; $display("FAIL round_mean7: got %h expected %h", meanOut[7*24 +: 24], ROUND_EXP); end
    n_cmp++; if (meanOut[9*24 +: 24] !== 24'hFF8001) begin n_fail++; $display("FAIL round_maxcnt: got %h expected ff8001", meanOut[9*24 +: 24]); end
    n_cmp++; if (meanOut !== pack_mean()) begin n_fail++; $display("FAIL round_mean: got %h expected %h", meanOut, pack_mean()); end
  endtask

  task automatic test_converge();
    int lat, dc; logic bs; bit chg; logic [383:0] first;
    fill_default(20);
    run_pass(200, lat, bs, dc);
    chg = model_pass();
    first = meanOut;
    n_cmp++; if (lat != LAT_ALL) begin n_fail++; $display("FAIL conv1_latency: got %0d expected %0d", lat, LAT_ALL); end
    n_cmp++; if (converged !== 1'b0) begin n_fail++; $display("FAIL conv1_conv: got %b expected 0", converged); end
    n_cmp++; if (converged !== !chg) begin n_fail++; $display("FAIL conv1_model: got %b expected %b", converged, !chg); end
    n_cmp++; if (dc != 1) begin n_fail++; $display("FAIL conv1_done_width: got %0d expected 1", dc); end
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL conv1_no_restart: got busy %b expected 0", busy); end
      @(negedge clk);
    end
    run_pass(0, lat, bs, dc);
    chg = model_pass();
    n_cmp++; if (lat != LAT_ALL) begin n_fail++; $display("FAIL conv2_latency: got %0d expected %0d", lat, LAT_ALL); end
    n_cmp++; if (converged !== 1'b1) begin n_fail++; $display("FAIL conv2_conv: got %b expected 1", converged); end
    n_cmp++; if (meanOut !== first) begin n_fail++; $display("FAIL conv2_mean: got %h expected %h", meanOut, first); end
    n_cmp++; if (meanOut !== pack_mean()) begin n_fail++; $display("FAIL conv2_model: got %h expected %h", meanOut, pack_mean()); end
  endtask

  task automatic test_reset_midpass();
    logic [383:0] rp; int done_seen;
    fill_default(30);
    drive_inputs();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (500) @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_before: got %b expected 1", busy); end
    #2 reset = 1'b0;
    #1;
    model_reset();
    rp = pack_mean();
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b expected 0", busy); end
    n_cmp++; if (enabled !== 16'hFFFF) begin n_fail++; $display("FAIL mid_en: got %h expected ffff", enabled); end
    n_cmp++; if (meanOut !== rp) begin n_fail++; $display("FAIL mid_mean: got %h expected %h", meanOut, rp); end
    n_cmp++; if (converged !== 1'b0) begin n_fail++; $display("FAIL mid_conv: got %b expected 0", converged); end
    done_seen = 0;
    repeat (3) begin @(negedge clk); if (done !== 1'b0) done_seen++; end
    reset = 1'b1;
    repeat (20) begin @(negedge clk); if (done !== 1'b0 || busy !== 1'b0) done_seen++; end
    n_cmp++; if (done_seen != 0) begin n_fail++; $display("FAIL mid_no_done: got %0d active cycles expected 0", done_seen); end
  endtask

  task automatic test_recover();
    int lat, dc; logic bs; bit chg;
    fill_default(40);
    run_pass(0, lat, bs, dc);
    chg = model_pass();
    n_cmp++; if (lat != LAT_ALL) begin n_fail++; $display("FAIL rec_latency: got %0d expected %0d", lat, LAT_ALL); end
    n_cmp++; if (meanOut !== pack_mean()) begin n_fail++; $display("FAIL rec_mean: got %h expected %h", meanOut, pack_mean()); end
    n_cmp++; if (converged !== !chg) begin n_fail++; $display("FAIL rec_conv: got %b expected %b", converged, !chg); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_cluster();
    test_saturate();
    test_round();
    test_converge();
    test_reset_midpass();
    test_recover();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
